// File: rtl/rv_writeback_stage.sv
`default_nettype none
// ============================================================================
//  Module   : rv_writeback_stage
//  Purpose  : RISC-V writeback / PC-update stage. Accepts one decoded
//             instruction per handshake, computes the destination register
//             value and the next PC, and emits a one-cycle retire pulse.
//             Loads park in WAIT_LOAD until the load data returns.
//  Ports    : i_clk, i_rst_n            clock, async active-low reset
//             i_valid / o_ready         instruction handshake
//             i_opcode, i_rd_addr,
//             i_alu_out, i_pc, i_imm,
//             i_rs1                     instruction fields
//             i_load_valid, i_load_data load return
//             i_flush                   cancel in-flight instruction
//             o_valid, o_wr_rd,
//             o_rd_addr, o_rd           retire pulse and register write
//             o_pc_new, o_change_pc,
//             o_trap                    control-flow result
//             o_instret                 retired-instruction counter
//  Revision : 1.0 - initial release
// ============================================================================
module rv_writeback_stage #(
    parameter int              XLEN          = 32,
    parameter logic [XLEN-1:0] RESET_PC      = '0,
    parameter int              CNT_W         = 64,
    parameter bit              TRAP_MISALIGN = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [6:0]       i_opcode,
    input  logic [4:0]       i_rd_addr,
    input  logic [XLEN-1:0]  i_alu_out,
    input  logic [XLEN-1:0]  i_pc,
    input  logic [XLEN-1:0]  i_imm,
    input  logic [XLEN-1:0]  i_rs1,
    input  logic             i_load_valid,
    input  logic [XLEN-1:0]  i_load_data,
    input  logic             i_flush,
    output logic             o_valid,
    output logic             o_wr_rd,
    output logic [4:0]       o_rd_addr,
    output logic [XLEN-1:0]  o_rd,
    output logic [XLEN-1:0]  o_pc_new,
    output logic             o_change_pc,
    output logic             o_trap,
    output logic [CNT_W-1:0] o_instret
);

    localparam logic [6:0] c_OP_R_TYPE = 7'b0110011;
    localparam logic [6:0] c_OP_I_TYPE = 7'b0010011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] c_OP_FENCE  = 7'b0001111;

    localparam logic [XLEN-1:0]  c_FOUR    = XLEN'(4);
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    typedef enum logic [0:0] {
        S_IDLE      = 1'b0,
        S_WAIT_LOAD = 1'b1
    } state_t;

    state_t            r_state;
    logic [4:0]        r_ld_rd_addr;   // parked load destination
    logic [XLEN-1:0]   r_ld_pc;        // parked load PC (for seq next PC)
    logic              r_valid;
    logic              r_wr_rd;
    logic [4:0]        r_rd_addr;
    logic [XLEN-1:0]   r_rd;
    logic [XLEN-1:0]   r_pc_new;
    logic              r_change_pc;
    logic              r_trap;
    logic [CNT_W-1:0]  r_instret;

    logic              w_hs;
    logic              w_is_jalr;
    logic [XLEN-1:0]   w_add_a;
    logic [XLEN-1:0]   w_sum;
    logic [XLEN-1:0]   w_seq;
    logic [XLEN-1:0]   w_ld_seq;
    logic [XLEN-1:0]   w_target;
    logic              w_redirect;
    logic              w_misalign;
    logic              w_change;
    logic              w_wr;
    logic              w_no_write;
    logic [XLEN-1:0]   w_rd_val;

    // Ready is gated by the reset pin so it drops the moment reset asserts.
    assign o_ready = i_rst_n && (r_state == S_IDLE);
    // A flush in the handshake cycle cancels the handshake.
    assign w_hs    = i_valid && o_ready && !i_flush;

    // Single adder: JALR adds imm to rs1, every other user adds imm to pc.
    assign w_is_jalr = (i_opcode == c_OP_JALR);
    assign w_add_a   = w_is_jalr ? i_rs1 : i_pc;
    assign w_sum     = w_add_a + i_imm;
    assign w_seq     = i_pc + c_FOUR;
    assign w_ld_seq  = r_ld_pc + c_FOUR;
    assign w_target  = w_is_jalr ? {w_sum[XLEN-1:1], 1'b0} : w_sum;

    assign w_redirect = ((i_opcode == c_OP_BRANCH) && i_alu_out[0]) ||
                        (i_opcode == c_OP_JAL) || w_is_jalr;
    assign w_misalign = TRAP_MISALIGN && w_redirect && (w_target[1:0] != 2'b00);
    // A redirect whose target happens to equal pc+4 is not a PC change.
    assign w_change   = w_redirect && !w_misalign && (w_target != w_seq);
    assign w_wr       = !w_no_write && (i_rd_addr != 5'd0) && !w_misalign;

    always_comb begin
        w_rd_val   = '0;
        w_no_write = 1'b0;
        case (i_opcode)
            c_OP_R_TYPE, c_OP_I_TYPE: w_rd_val = i_alu_out;
            c_OP_LUI:                 w_rd_val = i_imm;
            c_OP_AUIPC:               w_rd_val = w_sum;
            c_OP_JAL, c_OP_JALR:      w_rd_val = w_seq;
            c_OP_BRANCH, c_OP_STORE,
            c_OP_SYSTEM, c_OP_FENCE:  w_no_write = 1'b1;
            default:                  w_rd_val = '0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_ld_rd_addr <= '0;
            r_ld_pc      <= '0;
            r_valid      <= 1'b0;
            r_wr_rd      <= 1'b0;
            r_rd_addr    <= '0;
            r_rd         <= '0;
            r_pc_new     <= RESET_PC;
            r_change_pc  <= 1'b0;
            r_trap       <= 1'b0;
            r_instret    <= '0;
        end else begin
            // Qualified outputs default low; data outputs hold.
            r_valid     <= 1'b0;
            r_wr_rd     <= 1'b0;
            r_change_pc <= 1'b0;
            r_trap      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_hs) begin
                        if (i_opcode == c_OP_LOAD) begin
                            r_state      <= S_WAIT_LOAD;
                            r_ld_rd_addr <= i_rd_addr;
                            r_ld_pc      <= i_pc;
                        end else begin
                            r_valid     <= 1'b1;
                            r_wr_rd     <= w_wr;
                            r_rd_addr   <= i_rd_addr;
                            r_rd        <= w_rd_val;
                            r_pc_new    <= w_redirect ? w_target : w_seq;
                            r_change_pc <= w_change;
                            r_trap      <= w_misalign;
                            if (!w_misalign) begin
                                r_instret <= r_instret + c_CNT_ONE;
                            end
                        end
                    end
                end
                S_WAIT_LOAD: begin
                    if (i_flush) begin
                        r_state <= S_IDLE;
                    end else if (i_load_valid) begin
                        r_state   <= S_IDLE;
                        r_valid   <= 1'b1;
                        r_wr_rd   <= (r_ld_rd_addr != 5'd0);
                        r_rd_addr <= r_ld_rd_addr;
                        r_rd      <= i_load_data;
                        r_pc_new  <= w_ld_seq;
                        r_instret <= r_instret + c_CNT_ONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_valid     = r_valid;
    assign o_wr_rd     = r_wr_rd;
    assign o_rd_addr   = r_rd_addr;
    assign o_rd        = r_rd;
    assign o_pc_new    = r_pc_new;
    assign o_change_pc = r_change_pc;
    assign o_trap      = r_trap;
    assign o_instret   = r_instret;

endmodule
`default_nettype wire

// File: doc/rv_writeback_stage.md
RV_WRITEBACK_STAGE -- requirements
Module: rv_writeback_stage

Interface
REQ-001 Parameters SHALL be: XLEN, default 32, datapath width; RESET_PC, default 0, o_pc_new reset value; CNT_W, default 64, retire counter width; TRAP_MISALIGN, default 1, enables the misaligned-target check.
REQ-002 One clock; reset is asynchronous and active-low: i_clk input 1, clock; i_rst_n input 1, asynchronous active-low reset.
REQ-003 i_valid input 1 marks an instruction offered. o_ready output 1 indicates the stage accepts it.
REQ-004 Instruction fields SHALL be: i_opcode input 7; i_rd_addr input 5; i_alu_out input XLEN; i_pc input XLEN; i_imm input XLEN; i_rs1 input XLEN.
REQ-005 Load return SHALL be: i_load_valid input 1; i_load_data input XLEN.
REQ-006 i_flush input 1 cancels the in-flight instruction.
REQ-007 o_valid output 1 is a one-cycle retire pulse. o_wr_rd output 1 is the register write enable. o_rd_addr output 5. o_rd output XLEN is the writeback value.
REQ-008 Control-flow outputs SHALL be: o_pc_new output XLEN, next PC; o_change_pc output 1, redirect to a non-sequential PC; o_trap output 1, misaligned target.
REQ-009 o_instret output CNT_W counts retired instructions.

Function
REQ-010 Opcodes SHALL be: R_TYPE 0110011, I_TYPE 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111, SYSTEM 1110011, FENCE 0001111.
REQ-011 A handshake SHALL occur on a rising edge where i_valid && o_ready. Inputs SHALL be sampled only then.
REQ-012 The FSM SHALL have states IDLE and WAIT_LOAD, with o_ready=1 only in IDLE.
REQ-013 In IDLE, handshake on non-LOAD -> results registered, o_valid=1 the next cycle, FSM stays IDLE (latency 1, throughput 1/cycle).
REQ-014 In IDLE, handshake on LOAD -> WAIT_LOAD. Opcode, rd_addr and pc are held internally.
REQ-015 In WAIT_LOAD, i_load_valid=1 -> o_rd=i_load_data, o_valid=1 the next cycle, FSM returns to IDLE.
REQ-016 i_load_valid in IDLE SHALL be ignored.
REQ-017 The default next PC SHALL be seq = pc + 4, modulo 2^XLEN.
REQ-018 o_rd selection SHALL be: R/I_TYPE -> alu_out; LUI -> imm; AUIPC -> pc+imm; JAL/JALR -> seq; others -> 0.
REQ-019 o_pc_new selection SHALL be: BRANCH with alu_out[0]=1 -> pc+imm; JAL -> pc+imm; JALR -> (rs1+imm) with bit0 cleared; otherwise seq.
REQ-020 o_change_pc SHALL be 1 exactly when o_pc_new != seq due to a taken branch, JAL or JALR.
REQ-021 One shared adder SHALL serve all a+imm sums. All arithmetic SHALL wrap at XLEN bits.
REQ-022 When TRAP_MISALIGN=1 and a redirect target has bits[1:0] != 0, the stage SHALL assert o_trap=1, o_wr_rd=0, o_change_pc=0, o_pc_new=target, with o_valid=1.
REQ-023 o_wr_rd SHALL be 0 for BRANCH, STORE, SYSTEM, FENCE, rd_addr==0 or trap, and 1 otherwise.
REQ-024 o_wr_rd, o_change_pc and o_trap SHALL be qualified: 0 whenever o_valid=0.
REQ-025 o_rd, o_pc_new and o_rd_addr SHALL hold their last value while o_valid=0.
REQ-026 o_instret SHALL increment by 1 on each o_valid=1 cycle where o_trap=0, and wrap at 2^CNT_W.
REQ-027 i_flush=1 SHALL discard any handshake that cycle and any WAIT_LOAD instruction. FSM -> IDLE, no o_valid next cycle.
REQ-028 i_flush and i_load_valid in the same cycle: flush SHALL win.
REQ-029 Unknown opcode SHALL retire with o_rd=0, o_wr_rd=1 if rd_addr!=0, and o_pc_new=seq.

Reset
REQ-030 While i_rst_n=0, the stage SHALL force FSM=IDLE, o_valid=0, o_wr_rd=0, o_change_pc=0, o_trap=0, o_rd=0, o_rd_addr=0, o_pc_new=RESET_PC, o_instret=0.
REQ-031 o_ready SHALL be 0 while in reset and 1 on the first cycle after deassertion.
REQ-032 Reset mid-WAIT_LOAD SHALL drop the load. A later i_load_valid SHALL have no effect.

Verification
REQ-033 ADD: I_TYPE, rd=5, alu_out=0x10, pc=0x100 -> next cycle o_valid=1, o_wr_rd=1, o_rd=0x10, o_pc_new=0x104, o_instret=1.
REQ-034 JALR: rs1=0x2001, imm=4, pc=0x40, rd=1 -> o_pc_new=0x2004, o_rd=0x44, o_change_pc=1. Same with imm=6 -> o_trap=1, o_wr_rd=0, o_instret unchanged.
REQ-035 LOAD: rd=3, i_load_valid after 3 cycles with data 0xDEADBEEF -> o_ready=0 for those 3 cycles, then o_valid=1, o_rd=0xDEADBEEF, o_pc_new=pc+4.
REQ-036 LOAD then i_flush in WAIT_LOAD, simultaneous with i_load_valid -> no o_valid, o_ready=1 next cycle, o_instret unchanged.
REQ-037 BRANCH: alu_out[0]=0 at pc=0x80, imm=0x20 -> o_pc_new=0x84, o_change_pc=0; alu_out[0]=1 -> o_pc_new=0xA0, o_change_pc=1; o_wr_rd=0 both.
REQ-038 Back-to-back: 4 I_TYPE with rd=0 and i_valid held -> 4 consecutive o_valid pulses, o_wr_rd=0, o_instret=4; assert i_rst_n=0 mid-stream -> all outputs at reset values immediately.
